button_conditioner: RTL

Per-button input conditioner that sits directly upstream of the ALU top level, between the raw board pushbuttons (btnL, btnC, btnR) and the registers that latch operand A, operand B and the opcode from the switches. Each button passes through a 2-flop synchronizer and a counter-based debouncer. The block outputs a clean level and a single-cycle press pulse per button, so each physical press loads the switches exactly once.

---
 rtl/button_conditioner_if.sv | 12 +
 rtl/button_conditioner.sv | 67 ++++++
 2 files changed

// File: rtl/button_conditioner_if.sv
// Button conditioner bus: raw button levels in, debounced levels and press pulses out.
`timescale 1ns/1ps
interface button_conditioner_if #(
   parameter int unsigned N_BOTON = 3
);
   logic [N_BOTON-1:0] i_btn;
   logic [N_BOTON-1:0] o_level;
   logic [N_BOTON-1:0] o_pulse;

   modport master (output i_btn, input o_level, input o_pulse);
   modport slave  (input i_btn, output o_level, output o_pulse);
endinterface

// File: rtl/button_conditioner.sv
// Per-button 2-flop synchronizer, counter debouncer and rising-edge press pulse.
// Channels are fully independent; each physical press yields one single-cycle pulse.
`timescale 1ns/1ps
module button_conditioner #(
   parameter int unsigned N_BOTON         = 3,
   parameter int unsigned DEBOUNCE_CYCLES = 1000000,
   parameter int unsigned NB_COUNTER      = $clog2(DEBOUNCE_CYCLES) + 1
) (
   input  logic                 clk,
   input  logic                 i_rst_n,
   button_conditioner_if.slave  bus
);

   localparam logic [NB_COUNTER-1:0] CNT_LAST = NB_COUNTER'(DEBOUNCE_CYCLES - 1);

   logic [N_BOTON-1:0]    sync1_q;
   logic [N_BOTON-1:0]    sync2_q;
   logic [N_BOTON-1:0]    stable_q;
   logic [N_BOTON-1:0]    stable_d;
   logic [N_BOTON-1:0]    pulse_q;
   logic [N_BOTON-1:0]    pulse_d;
   logic [NB_COUNTER-1:0] cnt_q [N_BOTON];
   logic [NB_COUNTER-1:0] cnt_d [N_BOTON];

   // Debounce next state: any return to the stable value discards the partial count
   always_comb begin
      stable_d = stable_q;
      pulse_d  = '0;
      cnt_d    = cnt_q;
      for (int unsigned i = 0; i < N_BOTON; i++) begin
         if (sync2_q[i] == stable_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CNT_LAST) begin
            stable_d[i] = sync2_q[i];
            pulse_d[i]  = sync2_q[i];
            cnt_d[i]    = '0;
         end else begin
            cnt_d[i] = cnt_q[i] + NB_COUNTER'(1);
         end
      end
   end

   // State registers
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sync1_q  <= '0;
         sync2_q  <= '0;
         stable_q <= '0;
         pulse_q  <= '0;
         for (int unsigned i = 0; i < N_BOTON; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         sync1_q  <= bus.i_btn;
         sync2_q  <= sync1_q;
         stable_q <= stable_d;
         pulse_q  <= pulse_d;
         for (int unsigned i = 0; i < N_BOTON; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign bus.o_level = stable_q;
   assign bus.o_pulse = pulse_q;

endmodule
